// File: rtl/alu8_cmd_sequencer.sv
// Command FIFO plus IDLE/EXEC/DONE sequencer that drives an external 8-bit ALU and holds its result.
// Optional macro ALU8_SEQ_FLAGS_EN adds res_zero/res_parity outputs captured with res_data.
module alu8_cmd_sequencer #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic [2:0] cmd_sel,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_sel,
  input  logic [7:0] alu_out,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic [2:0] res_sel
`ifdef ALU8_SEQ_FLAGS_EN
  ,
  output logic       res_zero,
  output logic       res_parity
`endif
);

  // FIFO_DEPTH is a power of two, so the pointers wrap by plain overflow.
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [18:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic [1:0]    r_state;
  logic [7:0]    r_aluA;
  logic [7:0]    r_aluB;
  logic [2:0]    r_aluSel;
  logic          r_resValid;
  logic [7:0]    r_resData;
  logic [2:0]    r_resSel;

  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [18:0]   w_head;

  assign w_empty   = (r_count == '0);
  assign cmd_ready = (r_count != DEPTH_C);
  assign w_push    = cmd_valid && cmd_ready;
  assign w_pop     = !w_empty &&
                     ((r_state == S_IDLE) || ((r_state == S_DONE) && res_ready));
  assign w_head    = r_mem[r_rdPtr];

  assign alu_a     = r_aluA;
  assign alu_b     = r_aluB;
  assign alu_sel   = r_aluSel;
  assign res_valid = r_resValid;
  assign res_data  = r_resData;
  assign res_sel   = r_resSel;

  // Storage needs no reset: the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= {cmd_sel, cmd_a, cmd_b};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_aluA     <= '0;
      r_aluB     <= '0;
      r_aluSel   <= '0;
      r_resValid <= 1'b0;
      r_resData  <= '0;
      r_resSel   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            {r_aluSel, r_aluA, r_aluB} <= w_head;
            r_state                    <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_resData  <= alu_out;
          r_resSel   <= r_aluSel;
          r_resValid <= 1'b1;
          r_state    <= S_DONE;
        end
        S_DONE: begin
          if (res_ready) begin
            r_resValid <= 1'b0;
            if (w_pop) begin
              {r_aluSel, r_aluA, r_aluB} <= w_head;
              r_state                    <= S_EXEC;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ALU8_SEQ_FLAGS_EN
  logic r_resZero;
  logic r_resParity;

  assign res_zero   = r_resZero;
  assign res_parity = r_resParity;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_resZero   <= 1'b0;
      r_resParity <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_resZero   <= (alu_out == 8'h00);
      r_resParity <= ^alu_out;
    end
  end
`endif

endmodule

// File: doc/alu8_cmd_sequencer.md
ALU8_CMD_SEQUENCER -- requirements
Module: alu8_cmd_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: command FIFO entries; SHALL be a power of two, at least 2.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 cmd_valid  input  1  upstream command present.
REQ-005 cmd_ready  output  1  sequencer can accept a command.
REQ-006 cmd_a  input  8  operand A of command.
REQ-007 cmd_b  input  8  operand B of command.
REQ-008 cmd_sel  input  3  ALU opcode (000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NAND, 110 NOR, 111 XNOR).
REQ-009 alu_a  output  8  registered operand A to the combinational 8-bit ALU.
REQ-010 alu_b  output  8  registered operand B to the ALU.
REQ-011 alu_sel  output  3  registered opcode to the ALU.
REQ-012 alu_out  input  8  ALU result, combinational from alu_a/alu_b/alu_sel.
REQ-013 res_valid  output  1  captured result available.
REQ-014 res_ready  input  1  downstream accepts result.
REQ-015 res_data  output  8  captured ALU result.
REQ-016 res_sel  output  3  opcode that produced res_data.

Function
REQ-017 Command transfer SHALL occur on a rising edge where cmd_valid and cmd_ready are both 1; the command SHALL be pushed to the FIFO tail.
REQ-018 cmd_ready SHALL equal (FIFO occupancy != FIFO_DEPTH), independent of same-cycle pops.
REQ-019 cmd_valid while cmd_ready=0 SHALL be ignored; FIFO contents SHALL be unchanged.
REQ-020 FSM states: IDLE, EXEC, DONE.
REQ-021 IDLE: if FIFO non-empty, pop head into alu_a/alu_b/alu_sel and go EXEC; else stay.
REQ-022 EXEC: capture alu_out into res_data and alu_sel into res_sel, set res_valid=1, go DONE; lasts exactly one cycle.
REQ-023 DONE: hold res_valid, res_data, res_sel stable until res_ready=1.
REQ-024 DONE with res_ready=1: if FIFO non-empty pop head into operand registers, clear res_valid, go EXEC; else clear res_valid, go IDLE.
REQ-025 Latency: command accepted at edge N into an empty FIFO with FSM in IDLE SHALL produce res_valid=1 after edge N+2.
REQ-026 Sustained throughput with res_ready=1 SHALL be one result per two cycles.
REQ-027 Simultaneous push and pop SHALL keep occupancy unchanged and preserve FIFO order.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH with no loss or duplication.
REQ-029 alu_a/alu_b/alu_sel SHALL change only on a pop edge.

Reset
REQ-030 rst=1 at an edge SHALL force FSM=IDLE, FIFO empty, res_valid=0, res_data=0, res_sel=0, alu_a=0, alu_b=0, alu_sel=0; cmd_ready=1 after release.
REQ-031 Reset mid-operation SHALL discard queued commands and any in-flight or held result; no res_valid pulse after reset.
REQ-032 cmd_valid during rst=1 SHALL NOT be accepted.

Configuration
REQ-033 Macro ALU8_SEQ_FLAGS_EN defined: adds outputs res_zero (1, res_data==0) and res_parity (1, XOR of res_data bits), captured in EXEC with res_data, reset to 0.
REQ-034 Macro ALU8_SEQ_FLAGS_EN undefined: res_zero and res_parity ports and logic SHALL be absent; all other behaviour identical.

Verification
REQ-035 Idle, res_ready=1, push A=0x0F B=0x01 sel=000 at edge N -> alu_a=0x0F after N+1, res_valid=1 res_data=0x10 res_sel=000 after N+2.
REQ-036 Push A=0x0F B=0x01 sel=001, then A=0xCC B=0xAA sel=100, res_ready=1 -> results 0x0E then 0x66, in order, two cycles apart.
REQ-037 res_ready=0, cmd_valid=1 for 6 cycles with FIFO_DEPTH=4 -> exactly 5 accepted, cmd_ready=0 thereafter, res_data stable.
REQ-038 From REQ-037 state, raise res_ready -> 5 results in push order, cmd_ready returns 1 after first pop; wrap-around exercised.
REQ-039 Assert rst while in DONE with 3 queued -> next cycle res_valid=0, cmd_ready=1, no further results.
REQ-040 With ALU8_SEQ_FLAGS_EN: A=0xCC B=0xCC sel=100 -> res_data=0x00, res_zero=1, res_parity=0.
